// File: rtl/audio_pkg.sv
// Shared audio definitions: framing mode codes, word-select polarity, stereo pair type.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package audio_pkg;

  // Framing selection sampled at each frame boundary
  localparam logic MODE_LJ  = 1'b0;  // MSB in the first bit of the slot
  localparam logic MODE_I2S = 1'b1;  // MSB one BCK after the WS edge

  // Word-select level for each channel slot
  localparam logic WS_RIGHT = 1'b0;
  localparam logic WS_LEFT  = 1'b1;

  // Canonical 16-bit stereo sample pair as produced by the tone/music generators
  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
  } stereo16_t;

endpackage

// File: rtl/i2s_tx_param_if.sv
// Sample-pair stream into the serializer: one left/right pair per valid/ready beat.
// Latency: n/a (wires only).
// Backpressure: s_ready low holds the producer; data must stay stable while s_valid is high.
// Ports: s_valid (producer), s_ready (consumer), s_left/s_right (producer, two's complement).
interface i2s_tx_param_if #(
  parameter int SAMPLE_W = 16
);

  logic                s_valid;
  logic                s_ready;
  logic [SAMPLE_W-1:0] s_left;
  logic [SAMPLE_W-1:0] s_right;

  modport master (output s_valid, s_left, s_right, input s_ready);
  modport slave  (input s_valid, s_left, s_right, output s_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with valid/ready push side and a pop strobe on the read side.
// Latency: a pushed word is visible on o_pop_dat the cycle after the push.
// Backpressure: o_push_rdy low when full; a pop in the same cycle does not open the push.
// Ports: clk/rst_n, i_push_vld/o_push_rdy/i_push_dat, i_pop/o_pop_dat, o_empty, o_level.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push_vld,
  output logic                     o_push_rdy,
  input  logic [WIDTH-1:0]         i_push_dat,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_pop_dat,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push;
  logic             w_pop;

  // Full is judged on the registered level only, so no same-cycle bypass
  assign o_push_rdy = (r_level != LVL_FULL);
  assign o_empty    = (r_level == '0);
  assign o_level    = r_level;
  assign o_pop_dat  = r_mem[r_rd_ptr];
  assign w_push     = i_push_vld && o_push_rdy;
  assign w_pop      = i_pop && !o_empty;

  // DEPTH is a power of two, so the pointers wrap by plain overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/i2s_tx_param.sv
// Stereo audio serializer: FIFO-buffered sample pairs out as LJ or I2S frames to the DAC.
// Latency: a pair pushed into an empty FIFO goes out from the first BCK of the next frame.
// Backpressure: s_ready = FIFO not full; one pair drains per frame (also while muted).
// Ports: clk, rst_n, s_if (slave pair stream), mode, mute, audio_APPSEL/SYSCLK/BCK/WS/DATA,
//        underrun (1-clk pulse when a frame starts empty), fifo_level (occupancy).
module i2s_tx_param
  import audio_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int SLOT_W     = 16,
  parameter int BCK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  i2s_tx_param_if.slave                 s_if,
  input  logic                          mode,
  input  logic                          mute,
  output logic                          audio_APPSEL,
  output logic                          audio_SYSCLK,
  output logic                          audio_BCK,
  output logic                          audio_WS,
  output logic                          audio_DATA,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV_W = $clog2(BCK_DIV);
  localparam int BIT_W = (SLOT_W > 1) ? $clog2(2 * SLOT_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCK_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] SLOT_B   = BIT_W'(SLOT_W);

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } pair_t;

  logic [DIV_W-1:0]    r_div_cnt;
  logic [BIT_W-1:0]    r_bit_cnt;
  pair_t               r_shadow;
  logic                r_mode;
  logic                r_bck;
  logic                r_ws;
  logic                r_data;
  logic                r_underrun;

  logic [DIV_W-1:0]    w_div_nxt;
  logic [BIT_W-1:0]    w_bit_nxt;
  logic                w_div_wrap;
  logic                w_frame_end;
  pair_t               w_push_pair;
  pair_t               w_fifo_pair;
  logic                w_fifo_empty;
  logic                w_pop;
  pair_t               w_shadow_nxt;
  logic                w_mode_nxt;
  logic                w_left_slot;
  logic [BIT_W-1:0]    w_pos;
  logic [SAMPLE_W-1:0] w_word;
  logic [SAMPLE_W-1:0] w_shifted;
  logic [BIT_W-1:0]    w_ws_idx;
  logic                w_ws_nxt;
  logic                w_data_nxt;

  assign w_push_pair = '{left: s_if.s_left, right: s_if.s_right};

  sync_fifo #(
    .WIDTH (2 * SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push_vld (s_if.s_valid),
    .o_push_rdy (s_if.s_ready),
    .i_push_dat (w_push_pair),
    .i_pop      (w_pop),
    .o_pop_dat  (w_fifo_pair),
    .o_empty    (w_fifo_empty),
    .o_level    (fifo_level)
  );

  // Bit timing: div_cnt paces one BCK, bit_cnt walks the right slot then the left slot
  assign w_div_wrap  = (r_div_cnt == DIV_LAST);
  assign w_div_nxt   = w_div_wrap ? '0 : r_div_cnt + DIV_ONE;
  assign w_frame_end = w_div_wrap && (r_bit_cnt == BIT_LAST);
  assign w_bit_nxt   = w_frame_end ? '0 : (w_div_wrap ? r_bit_cnt + BIT_ONE : r_bit_cnt);
  assign w_pop       = w_frame_end && !w_fifo_empty;

  // Frame boundary: latch the next pair (zeros if muted or starved) plus the framing mode.
  // Muting still pops so the drain rate never depends on mute.
  always_comb begin
    w_shadow_nxt = r_shadow;
    w_mode_nxt   = r_mode;
    if (w_frame_end) begin
      w_mode_nxt   = mode;
      w_shadow_nxt = (w_fifo_empty || mute) ? '0 : w_fifo_pair;
    end
  end

  // Next serial bit and WS, evaluated for the bit that starts on this BCK falling edge.
  // Uses the post-boundary shadow/mode so bit 0 of a frame already carries the new pair.
  always_comb begin
    w_left_slot = (w_bit_nxt >= SLOT_B);
    w_pos       = w_left_slot ? (w_bit_nxt - SLOT_B) : w_bit_nxt;
    w_word      = w_left_slot ? w_shadow_nxt.left : w_shadow_nxt.right;
    // Shifting past the sample width yields the zero padding for free
    w_shifted   = w_word << w_pos;
    w_data_nxt  = w_shifted[SAMPLE_W-1];
    // I2S leads WS by one bit so the MSB follows the WS edge by one BCK
    if (w_mode_nxt == MODE_I2S) begin
      w_ws_idx = (w_bit_nxt == BIT_LAST) ? '0 : w_bit_nxt + BIT_ONE;
    end else begin
      w_ws_idx = w_bit_nxt;
    end
    w_ws_nxt = (w_ws_idx >= SLOT_B) ? WS_LEFT : WS_RIGHT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_shadow   <= '0;
      r_mode     <= MODE_LJ;
      r_bck      <= 1'b0;
      r_ws       <= WS_RIGHT;
      r_data     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_div_cnt  <= w_div_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shadow   <= w_shadow_nxt;
      r_mode     <= w_mode_nxt;
      r_bck      <= (w_div_nxt >= DIV_HALF);
      r_underrun <= w_frame_end && w_fifo_empty;
      // WS/DATA move only with the BCK falling edge, stable across the rising edge
      if (w_div_wrap) begin
        r_ws   <= w_ws_nxt;
        r_data <= w_data_nxt;
      end
    end
  end

  assign audio_APPSEL = 1'b0;
  assign audio_SYSCLK = clk;
  assign audio_BCK    = r_bck;
  assign audio_WS     = r_ws;
  assign audio_DATA   = r_data;
  assign underrun     = r_underrun;

endmodule
